branch_cmp_pipe: RTL

BRANCH_CMP_PIPE -- requirements
Module: branch_cmp_pipe

---
 rtl/cmp_pkg.sv | 25 ++
 rtl/cmp_stage.sv | 34 +++
 rtl/branch_cmp_pipe.sv | 82 ++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the branch comparator: mode encodings and the
// flag bundle produced by a single comparison.
package cmp_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LTU = 3'd4,
    CMP_GEU = 3'd5,
    CMP_LEZ = 3'd6,
    CMP_GTZ = 3'd7
  } cmp_mode_e;

  typedef struct packed {
    logic taken;
    logic eq;
    logic lt;
    logic ltu;
  } cmp_flags_t;

endpackage

// File: rtl/cmp_stage.sv
// One elastic pipeline stage: a valid bit plus payload register, with
// flush clearing the valid bit and reset clearing everything.
module cmp_stage #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  input  logic          down_ready,
  output logic          up_ready,
  output logic          valid,
  output logic [PW-1:0] data
);

  // Loadable when empty or when the current content is leaving this edge.
  assign up_ready = !valid || down_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush)
        valid <= 1'b0;
      else if (up_ready)
        valid <= in_valid;
      if (up_ready && in_valid)
        data <= in_data;
    end
  end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Pipelined branch comparator: flags are computed at acceptance and carried
// through STAGES valid/ready register stages with flush support.
module branch_cmp_pipe
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [MODE_W-1:0] mode,
  input  logic [TAG_W-1:0]  tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              taken,
  output logic              eq,
  output logic              lt,
  output logic              ltu,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned PW = 4 + TAG_W;

  cmp_flags_t f;
  logic       a_neg;
  logic       a_zero;

  always_comb begin
    f      = '0;
    a_neg  = a[WIDTH-1];
    a_zero = (a == '0);
    f.eq   = (a == b);
    f.lt   = ($signed(a) < $signed(b));
    f.ltu  = (a < b);
    unique case (cmp_mode_e'(mode))
      CMP_EQ:  f.taken = f.eq;
      CMP_NE:  f.taken = !f.eq;
      CMP_LT:  f.taken = f.lt;
      CMP_GE:  f.taken = !f.lt;
      CMP_LTU: f.taken = f.ltu;
      CMP_GEU: f.taken = !f.ltu;
      CMP_LEZ: f.taken = a_neg || a_zero;
      CMP_GTZ: f.taken = !a_neg && !a_zero;
      default: f.taken = 1'b0;
    endcase
  end

  // Index 0 is the request port; index k is the output of stage k.
  // rdy[k] is stage k's load enable; rdy[STAGES+1] is the consumer.
  logic          vld [STAGES+1];
  logic [PW-1:0] dat [STAGES+1];
  logic          rdy [1:STAGES+1];

  assign vld[0]        = in_valid;
  assign dat[0]        = {f, tag};
  assign rdy[STAGES+1] = out_ready;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    cmp_stage #(.PW(PW)) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (vld[k-1]),
      .in_data    (dat[k-1]),
      .down_ready (rdy[k+1]),
      .up_ready   (rdy[k]),
      .valid      (vld[k]),
      .data       (dat[k])
    );
  end

  assign in_ready  = rdy[1] && !flush;
  assign out_valid = vld[STAGES];
  assign {taken, eq, lt, ltu, out_tag} = dat[STAGES];

endmodule
